sync_fifo_param: RTL and testbench

Parametrised synchronous FIFO: single clock, power-of-two depth, any data width.
Provides registered read data with a valid strobe, full/empty flags, programmable almost-full/almost-empty thresholds, an occupancy count, and overflow/underflow error pulses.
Used as the standard buffering element between producer and consumer blocks in the same clock domain.

---
 rtl/sync_fifo_param_if.sv | 29 ++
 rtl/sync_fifo_param.sv | 76 +++++++
 tb/tb_sync_fifo_param.sv | 102 ++++++++++
 3 files changed

// File: rtl/sync_fifo_param_if.sv
// sync_fifo_param_if: handshake bundle between a FIFO (slave) and its producer/consumer (master)
//   master drives wrt_en/wrt_dt/rd_en and observes read data, flags, fill_cnt and error pulses;
//   slave is the FIFO side of the same signals.
interface sync_fifo_param_if #(
  parameter int DT_WIDTH = 8,
  parameter int F_DEPTH  = 16
);
  localparam int FADD_WIDTH = $clog2(F_DEPTH);
  logic                wrt_en;
  logic [DT_WIDTH-1:0] wrt_dt;
  logic                rd_en;
  logic [DT_WIDTH-1:0] rd_dt;
  logic                rd_vld;
  logic                f_full;
  logic                f_empty;
  logic                almost_full;
  logic                almost_empty;
  logic [FADD_WIDTH:0] fill_cnt;
  logic                ovf;
  logic                udf;
  modport master (
    output wrt_en, wrt_dt, rd_en,
    input  rd_dt, rd_vld, f_full, f_empty, almost_full, almost_empty, fill_cnt, ovf, udf
  );
  modport slave (
    input  wrt_en, wrt_dt, rd_en,
    output rd_dt, rd_vld, f_full, f_empty, almost_full, almost_empty, fill_cnt, ovf, udf
  );
endinterface

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock power-of-two FIFO with flags, occupancy count and ovf/udf pulses
//   clk, rst : clock and synchronous active-high reset
//   bus      : sync_fifo_param_if.slave (write request/data, read request, read data/valid,
//              full/empty, almost_full/almost_empty, fill_cnt, ovf/udf)
//   SYNC_FIFO_FWFT_EN : when defined, the head word is shown on rd_dt whenever non-empty
//                       (first-word-fall-through); otherwise reads have one cycle of latency.
module sync_fifo_param #(
  parameter int DT_WIDTH  = 8,
  parameter int F_DEPTH   = 16,
  parameter int AF_THRESH = F_DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input logic clk,
  input logic rst,
  sync_fifo_param_if.slave bus
);
  localparam int FADD_WIDTH = $clog2(F_DEPTH);
  localparam logic [FADD_WIDTH:0] ONE  = (FADD_WIDTH+1)'(1);
  localparam logic [FADD_WIDTH:0] AF_T = (FADD_WIDTH+1)'(AF_THRESH);
  localparam logic [FADD_WIDTH:0] AE_T = (FADD_WIDTH+1)'(AE_THRESH);
  logic [DT_WIDTH-1:0]   mem_q [F_DEPTH];
  logic [FADD_WIDTH:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, cnt;
  logic                  f_full, f_empty, wr_acc, rd_acc;
  logic                  ovf_q, udf_q;
  always_comb begin
    f_empty  = wr_ptr_q == rd_ptr_q;
    // same slot but opposite wrap bits means the writer is a full lap ahead
    f_full   = (wr_ptr_q[FADD_WIDTH] != rd_ptr_q[FADD_WIDTH]) &&
               (wr_ptr_q[FADD_WIDTH-1:0] == rd_ptr_q[FADD_WIDTH-1:0]);
    wr_acc   = bus.wrt_en & ~f_full;
    rd_acc   = bus.rd_en & ~f_empty;
    wr_ptr_d = wr_acc ? wr_ptr_q + ONE : wr_ptr_q;
    rd_ptr_d = rd_acc ? rd_ptr_q + ONE : rd_ptr_q;
    cnt      = wr_ptr_q - rd_ptr_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= bus.wrt_en & f_full;
      udf_q    <= bus.rd_en & f_empty;
    end
  end
  always_ff @(posedge clk)
    if (wr_acc && !rst) mem_q[wr_ptr_q[FADD_WIDTH-1:0]] <= bus.wrt_dt;
`ifdef SYNC_FIFO_FWFT_EN
  assign bus.rd_dt  = mem_q[rd_ptr_q[FADD_WIDTH-1:0]];
  assign bus.rd_vld = ~f_empty;
`else
  logic [DT_WIDTH-1:0] rd_dt_q;
  logic                rd_vld_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_dt_q  <= '0;
      rd_vld_q <= 1'b0;
    end else begin
      rd_dt_q  <= rd_acc ? mem_q[rd_ptr_q[FADD_WIDTH-1:0]] : rd_dt_q;
      rd_vld_q <= rd_acc;
    end
  end
  assign bus.rd_dt  = rd_dt_q;
  assign bus.rd_vld = rd_vld_q;
`endif
  assign bus.f_full       = f_full;
  assign bus.f_empty      = f_empty;
  assign bus.fill_cnt     = cnt;
  assign bus.almost_full  = cnt >= AF_T;
  assign bus.almost_empty = cnt <= AE_T;
  assign bus.ovf          = ovf_q;
  assign bus.udf          = udf_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: directed and random stimulus checked every cycle against a queue model
module tb_sync_fifo_param;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_pass = 0;
  logic [7:0] q[$];
  logic [7:0] rd_e = 8'h00;
  bit   vld_e, ovf_e, udf_e;
  sync_fifo_param_if #(.DT_WIDTH(8), .F_DEPTH(16)) bus ();
  sync_fifo_param #(.DT_WIDTH(8), .F_DEPTH(16), .AF_THRESH(14), .AE_THRESH(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic check_outputs();
    int n = q.size();
    chk("fill_cnt", 32'(bus.fill_cnt), 32'(n));
    chk("f_empty", 32'(bus.f_empty), 32'(n == 0));
    chk("f_full", 32'(bus.f_full), 32'(n == 16));
    chk("almost_full", 32'(bus.almost_full), 32'(n >= 14));
    chk("almost_empty", 32'(bus.almost_empty), 32'(n <= 2));
    chk("ovf", 32'(bus.ovf), 32'(ovf_e));
    chk("udf", 32'(bus.udf), 32'(udf_e));
`ifdef SYNC_FIFO_FWFT_EN
    chk("rd_vld", 32'(bus.rd_vld), 32'(n != 0));
    if (n != 0) chk("rd_dt", 32'(bus.rd_dt), 32'(q[0]));
`else
    chk("rd_vld", 32'(bus.rd_vld), 32'(vld_e));
    chk("rd_dt", 32'(bus.rd_dt), 32'(rd_e));
`endif
  endtask
  // one clock: drive at the falling edge, model the rising edge, check at the next falling edge
  task automatic cyc(input bit we, input logic [7:0] wd, input bit re, input bit rs);
    bit full, empty;
    bus.wrt_en = we;
    bus.wrt_dt = wd;
    bus.rd_en  = re;
    rst        = rs;
    @(posedge clk);
    full  = q.size() == 16;
    empty = q.size() == 0;
    if (rs) begin
      q.delete();
      rd_e  = 8'h00;
      vld_e = 0;
      ovf_e = 0;
      udf_e = 0;
    end else begin
      ovf_e = we && full;
      udf_e = re && empty;
      vld_e = re && !empty;
      if (vld_e) rd_e = q.pop_front();
      if (we && !full) q.push_back(wd);
    end
    @(negedge clk);
    check_outputs();
  endtask
  initial begin
    logic [7:0] d = 8'h00;
    bus.wrt_en = 1'b0;
    bus.wrt_dt = 8'h00;
    bus.rd_en  = 1'b0;
    @(negedge clk);
    cyc(0, 8'h00, 0, 1);
    cyc(0, 8'h00, 0, 1);
    for (int i = 0; i < 4; i++) cyc(1, 8'(8'hA0 + i), 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 8'h00, 1, 0);
    for (int i = 0; i < 16; i++) cyc(1, 8'(8'h10 + 3 * i), 0, 0);
    cyc(1, 8'hEE, 0, 0);
    cyc(1, 8'hEF, 1, 0);
    for (int i = 0; i < 15; i++) cyc(0, 8'h00, 1, 0);
    cyc(0, 8'h00, 1, 0);
    cyc(1, 8'h77, 1, 0);
    cyc(0, 8'h00, 1, 0);
    for (int i = 0; i < 5; i++) cyc(1, 8'(8'hC0 + i), 0, 0);
    cyc(1, 8'hC5, 1, 0);
    for (int i = 0; i < 5; i++) cyc(0, 8'h00, 1, 0);
    for (int i = 0; i < 40; i++) begin
      cyc((i % 4) < 2, d, (i % 4) >= 2, 0);
      if ((i % 4) < 2) d++;
    end
    for (int i = 0; i < 9; i++) cyc(1, 8'(8'h30 + i), 0, 0);
    cyc(0, 8'h00, 0, 1);
    cyc(1, 8'h55, 0, 0);
    cyc(0, 8'h00, 1, 0);
    for (int i = 0; i < 400; i++) begin
      int pw = (i < 100) ? 75 : (i < 200) ? 25 : (i < 300) ? 50 : 90;
      int pr = (i < 100) ? 30 : (i < 200) ? 80 : (i < 300) ? 50 : 20;
      cyc($urandom_range(0, 99) < pw, 8'($urandom), $urandom_range(0, 99) < pr,
          $urandom_range(0, 149) == 0);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
